// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-requester burst weight.
// Optional feature macro: WRR_LOCK_EN adds lock_i to freeze the current burst.
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 3,
    parameter int IW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
`ifdef WRR_LOCK_EN
    input  logic            lock_i,
`endif
    input  logic [N-1:0]    rqt_i,
    input  logic [N*WW-1:0] weight_i,
    output logic [N-1:0]    gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            valid_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] cur;
    logic [IW-1:0] ptr;
    logic [WW-1:0] cnt;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic [WW-1:0] win_w;
    logic [WW-1:0] w_arr [N];
    logic          lock;
    logic          hold;

`ifdef WRR_LOCK_EN
    assign lock = lock_i;
`else
    assign lock = 1'b0;
`endif

    // Scan from the highest offset down so the requester closest to ptr wins;
    // the current grantee (offset N-1) is therefore considered last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (rqt_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) w_arr[i] = weight_i[i*WW +: WW];
        win_w = w_arr[win];
    end

    assign hold = (state == GRANT) && rqt_i[cur] && ((cnt != '0) || lock);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            cur   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt_o <= '0;
        end else if (hold) begin
            if (!lock) cnt <= cnt - 1'b1;
        end else if (found) begin
            state <= GRANT;
            cur   <= win;
            ptr   <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
            // a zero weight still buys a single cycle
            cnt   <= (win_w == '0) ? '0 : win_w - 1'b1;
            gnt_o <= {{(N-1){1'b0}}, 1'b1} << win;
        end else begin
            state <= IDLE;
            gnt_o <= '0;
        end
    end

    assign gnt_idx_o = cur;
    assign valid_o   = (state == GRANT);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_wrr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lock_r = 1'b0;
    logic [3:0]  rqt_i = '0;
    logic [11:0] weight_i = '0;
    logic [3:0]  gnt_o;
    logic [1:0]  gnt_idx_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       v;
        logic [1:0] idx;
        string      name;
    } exp_t;

    exp_t q[$];

    wrr_arbiter #(.N(4), .WW(3)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
`ifdef WRR_LOCK_EN
        .lock_i    (lock_r),
`endif
        .rqt_i     (rqt_i),
        .weight_i  (weight_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .valid_o   (valid_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    function automatic logic [11:0] pack(input int w0, input int w1, input int w2, input int w3);
        return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic rst, input logic [3:0] rqt, input logic [11:0] w,
                        input logic lk, input logic ev, input int eidx, input string nm);
        exp_t e;
        rst_ni   = rst;
        rqt_i    = rqt;
        weight_i = w;
        lock_r   = lk;
        e.cyc  = cyc + 1;
        e.v    = ev;
        e.idx  = 2'(eidx);
        e.name = nm;
        q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            logic [3:0] eg;
            e  = q.pop_front();
            eg = e.v ? (4'b0001 << e.idx) : 4'b0000;
            chk({e.name, ".valid"}, int'(valid_o), int'(e.v));
            chk({e.name, ".gnt"}, int'(gnt_o), int'(eg));
            chk({e.name, ".idx"}, int'(gnt_idx_o), int'(e.idx));
        end
    end

    initial begin
        logic [11:0] w1, w2, w4, w3, w5;
        int seq2 [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
        int seq_w [7] = '{1, 1, 1, 1, 1, 0, 0};
        w1 = pack(1, 1, 1, 1);
        w2 = pack(2, 2, 2, 2);
        w3 = pack(3, 3, 3, 3);
        w4 = pack(4, 4, 4, 4);
        w5 = pack(5, 5, 5, 5);

        // reset state
        step(1'b0, 4'h0, w1, 1'b0, 1'b0, 0, "rst0");
        step(1'b0, 4'hF, w1, 1'b0, 1'b0, 0, "rst1");

        // 1: weights 1, rqt A -> 1,3,1,3
        step(1'b1, 4'hA, w1, 1'b0, 1'b1, 1, "t1a");
        step(1'b1, 4'hA, w1, 1'b0, 1'b1, 3, "t1b");
        step(1'b1, 4'hA, w1, 1'b0, 1'b1, 1, "t1c");
        step(1'b1, 4'hA, w1, 1'b0, 1'b1, 3, "t1d");

        // 2: mixed weights incl. zero
        step(1'b0, 4'h0, w1, 1'b0, 1'b0, 0, "t2rst");
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'hF, pack(1, 2, 3, 0), 1'b0, 1'b1, seq2[i], $sformatf("t2_%0d", i));

        // 3: grantee drops request mid-burst, handoff with no idle
        step(1'b0, 4'h0, w4, 1'b0, 1'b0, 0, "t3rst");
        step(1'b1, 4'h3, w4, 1'b0, 1'b1, 0, "t3a");
        step(1'b1, 4'h3, w4, 1'b0, 1'b1, 0, "t3b");
        step(1'b1, 4'h2, w4, 1'b0, 1'b1, 1, "t3c");
        step(1'b1, 4'h2, w4, 1'b0, 1'b1, 1, "t3d");

        // 4: go idle (idx holds), single request, ptr resumes after it
        step(1'b1, 4'h0, w4, 1'b0, 1'b0, 1, "t4idle0");
        step(1'b1, 4'h0, w4, 1'b0, 1'b0, 1, "t4idle1");
        step(1'b1, 4'h4, w4, 1'b0, 1'b1, 2, "t4g2");
        step(1'b1, 4'h9, w4, 1'b0, 1'b1, 3, "t4ptr");
        step(1'b1, 4'h9, w4, 1'b0, 1'b1, 3, "t4hold");

        // 5: reset pulse mid-burst
        step(1'b0, 4'h0, w3, 1'b0, 1'b0, 0, "t5rst");
        step(1'b1, 4'hF, w3, 1'b0, 1'b1, 0, "t5a");
        step(1'b1, 4'hF, w3, 1'b0, 1'b1, 0, "t5b");
        step(1'b0, 4'hF, w3, 1'b0, 1'b0, 0, "t5pulse");
        step(1'b1, 4'hF, w3, 1'b0, 1'b1, 0, "t5c");
        step(1'b1, 4'hF, w3, 1'b0, 1'b1, 0, "t5d");
        step(1'b1, 4'hF, w3, 1'b0, 1'b1, 0, "t5e");
        step(1'b1, 4'hF, w3, 1'b0, 1'b1, 1, "t5f");

        // sole requester re-wins after its burst expires
        step(1'b0, 4'h0, w1, 1'b0, 1'b0, 0, "solerst");
        step(1'b1, 4'h2, w1, 1'b0, 1'b1, 1, "sole_a");
        step(1'b1, 4'h2, w1, 1'b0, 1'b1, 1, "sole_b");
        step(1'b1, 4'h2, w1, 1'b0, 1'b1, 1, "sole_c");

        // weight change mid-burst affects only the next grant
        step(1'b0, 4'h0, w2, 1'b0, 1'b0, 0, "wrst");
        step(1'b1, 4'h3, w2, 1'b0, 1'b1, 0, "w_a");
        step(1'b1, 4'h3, w5, 1'b0, 1'b1, 0, "w_b");
        for (int i = 0; i < 7; i++)
            step(1'b1, 4'h3, w5, 1'b0, 1'b1, seq_w[i], $sformatf("w_%0d", i));

`ifdef WRR_LOCK_EN
        // 6: lock freezes the burst, then it resumes from the frozen count
        step(1'b0, 4'h0, w2, 1'b0, 1'b0, 0, "t6rst");
        step(1'b1, 4'h3, w2, 1'b0, 1'b1, 0, "t6g");
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'h3, w2, 1'b1, 1'b1, 0, $sformatf("t6lock%0d", i));
        step(1'b1, 4'h3, w2, 1'b0, 1'b1, 0, "t6tail");
        step(1'b1, 4'h3, w2, 1'b0, 1'b1, 1, "t6move");
        step(1'b1, 4'h3, w2, 1'b0, 1'b1, 1, "t6hold1");
        // lock is ignored once the grantee drops its request
        step(1'b1, 4'h1, w2, 1'b1, 1'b1, 0, "t6drop");
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter that grants one of `N` requesters per cycle, with a per-requester burst weight. A granted requester keeps the grant for up to its weight in consecutive cycles before the grant rotates. It replaces the fixed-behaviour arbiter wherever shared resources need programmable bandwidth shares. Grants are registered, so `gnt_o` and `gnt_idx_o` can feed downstream muxes directly.

## Interface
- `N`, default 4: number of requesters, ≥2.
- `WW`, default 3: weight width in bits per requester.
- `IW`, default `$clog2(N)`: index width (derived, do not override).
- `clk_i`, input, 1: clock, rising edge.
- `rst_ni`, input, 1: reset, synchronous, active-low.
- `rqt_i`, input, N: request vector, bit i = requester i.
- `weight_i`, input, N*WW: weight of requester i in bits `[i*WW +: WW]`. Sampled only when a new grant is issued.
- `gnt_o`, output, N: one-hot grant, registered.
- `gnt_idx_o`, output, IW: binary index of the current grantee, registered.
- `valid_o`, output, 1: high when `gnt_o` is non-zero.
- `lock_i`, input, 1: present only with `WRR_LOCK_EN`.

## Operation
- State machine has two states:
  - IDLE: no grant.
  - GRANT: `gnt_o[cur]` set.
- Internal registers:
  - `cur` (IW bits): current grantee.
  - `ptr` (IW bits): search start.
  - `cnt` (WW bits): remaining extra cycles.
- Effective weight is `max(weight_i[i], 1)`; a weight of 0 is treated as 1.
- Each rising edge with `rst_ni` = 1:
  - Hold: in GRANT, if `rqt_i[cur]` = 1 and `cnt` ≠ 0, stay, `cnt` ← `cnt` − 1.
  - Otherwise re-arbitrate: scan `ptr, ptr+1, … ptr+N−1` (mod N) for the first set `rqt_i` bit.
    - Winner k: `cur` ← k, `ptr` ← (k+1) mod N, `cnt` ← `max(weight_i[k],1)` − 1, state GRANT.
    - No request: state IDLE, `gnt_o` ← 0; `ptr` unchanged.
- A grantee that drops its request loses the grant on the next edge. Re-arbitration happens on that same edge, so there are no idle cycles between grantees.
- The current grantee is searched last. A sole requester therefore re-wins immediately after its burst expires.
- At most one `gnt_o` bit is ever set. `gnt_idx_o` equals `cur` when `valid_o` = 1 and holds its last value when `valid_o` = 0.

## Timing
- Reset (`rst_ni` = 0 at an edge): `gnt_o` = 0, `gnt_idx_o` = 0, `valid_o` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
- Reset asserted mid-burst takes effect at that edge; the grant is dropped immediately.
- Latency: a request sampled at edge t from IDLE appears on `gnt_o` after edge t (one cycle).
- A requester with effective weight w and continuous request holds the grant for exactly w consecutive cycles.
- `rqt_i` changes in the same cycle as burst expiry: the new value is used for that edge's arbitration.
- `weight_i` changes during a burst do not affect the burst in progress.

## Configuration
- `WRR_LOCK_EN` defined:
  - Adds port `lock_i`.
  - In GRANT with `rqt_i[cur]` = 1 and `lock_i` = 1, the grant holds regardless of `cnt`, and `cnt` is frozen.
  - When `lock_i` falls, the burst resumes counting from the frozen `cnt`.
  - `lock_i` has no effect in IDLE or when `rqt_i[cur]` = 0.
- `WRR_LOCK_EN` undefined: no `lock_i` port; behaviour exactly as in Operation.

## Test plan
1. N=4, all weights 1, `rqt_i` = 4'hA held after reset → grant sequence 1, 3, 1, 3…, one cycle each, `valid_o` stays high.
2. Weights {w0=1, w1=2, w2=3, w3=0}, `rqt_i` = 4'hF → `gnt_idx_o` sequence 0, 1, 1, 2, 2, 2, 3, 0, 1, 1…
3. Weights all 4, `rqt_i` = 4'h3; drop bit 0 on the 2nd cycle of requester 0's burst → grant moves to 1 on the next edge; no idle cycle.
4. `rqt_i` goes to 0 → `gnt_o` = 0 and `valid_o` = 0 one cycle later. Then `rqt_i` = 4'h4 → grant 2 one cycle later, and `ptr` resumes correctly afterwards.
5. Reset pulse (`rst_ni` = 0 for 1 cycle) mid-burst of weight 3 → `gnt_o` = 0 after that edge. After release with `rqt_i` = 4'hF, the first grant goes to 0.
6. With `WRR_LOCK_EN`: weights all 2, `rqt_i` = 4'h3, `lock_i` = 1 for 5 cycles from grant 0 → requester 0 held 5+ cycles. After `lock_i` falls, it keeps the grant one more cycle, then the grant moves to 1.
